// File: rtl/tl45_pkg.sv
// Shared opcode, skip-mode and FSM definitions for the tl45 execute stage.
// TL45_ALU_DIV_EN enables the DIV/REM opcodes; without it they decode as no-ops.
package tl45_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_NAND = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_GOTO = 4'h5;
    localparam logic [3:0] OP_JALR = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;
    localparam logic [3:0] OP_SKP  = 4'h8;
    localparam logic [3:0] OP_LEA  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_DIV  = 4'hB;
    localparam logic [3:0] OP_REM  = 4'hC;

    typedef enum logic [1:0] {
        SKP_EQ = 2'd0,
        SKP_LT = 2'd1,
        SKP_NE = 2'd2,
        SKP_GE = 2'd3
    } skp_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

`ifdef TL45_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    function automatic logic is_mc_op(input logic [3:0] op);
        return (op == OP_MUL) || (DIV_EN && ((op == OP_DIV) || (op == OP_REM)));
    endfunction

    function automatic logic is_wb_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_NAND) || (op == OP_ADDI) ||
               (op == OP_JALR) || (op == OP_LEA) || is_mc_op(op);
    endfunction

endpackage

// File: rtl/tl45_alu_mc_if.sv
// Pipeline-facing signal bundle of the tl45 execute stage.
// master = upstream/driver side, slave = the execute stage itself.
interface tl45_alu_mc_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 4
);
    logic                i_pipe_stall;
    logic                i_pipe_flush;
    logic                o_pipe_stall;
    logic                o_pipe_flush;
    logic [XLEN-1:0]     i_pc;
    logic [XLEN-1:0]     i_target_address;
    logic [3:0]          i_opcode;
    logic [1:0]          i_skp_mode;
    logic [REG_BITS-1:0] i_dr;
    logic [XLEN-1:0]     i_sr1_val;
    logic [XLEN-1:0]     i_sr2_val;
    logic [REG_BITS-1:0] o_of_reg;
    logic [XLEN-1:0]     o_of_val;
    logic [REG_BITS-1:0] o_dr;
    logic [XLEN-1:0]     o_value;
    logic                o_ld_newpc;
    logic [XLEN-1:0]     o_br_pc;

    modport master (
        output i_pipe_stall, i_pipe_flush, i_pc, i_target_address, i_opcode,
               i_skp_mode, i_dr, i_sr1_val, i_sr2_val,
        input  o_pipe_stall, o_pipe_flush, o_of_reg, o_of_val, o_dr, o_value,
               o_ld_newpc, o_br_pc
    );

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_pc, i_target_address, i_opcode,
               i_skp_mode, i_dr, i_sr1_val, i_sr2_val,
        output o_pipe_stall, o_pipe_flush, o_of_reg, o_of_val, o_dr, o_value,
               o_ld_newpc, o_br_pc
    );
endinterface

// File: rtl/tl45_muldiv.sv
// Iterative shift-add multiplier and (with TL45_ALU_DIV_EN) restoring divider.
// One step per BUSY cycle; XLEN steps per operation, result held in DONE.
module tl45_muldiv
    import tl45_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            flush,
    input  logic            hold,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    mc_state_t       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [3:0]      op_reg;
    logic            busy_reg;
    logic            done_reg;
    // acc: product / partial remainder; opa: multiplicand / dividend->quotient; opb: multiplier / divisor
    logic [XLEN-1:0] acc_reg, opa_reg, opb_reg;
    logic [XLEN-1:0] acc_next, opa_next, opb_next;

`ifdef TL45_ALU_DIV_EN
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
`endif

    always_comb begin
        acc_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
        opa_next = opa_reg << 1;
        opb_next = opb_reg >> 1;
`ifdef TL45_ALU_DIV_EN
        rem_shift = {acc_reg, opa_reg[XLEN-1]};
        trial     = rem_shift - {1'b0, opb_reg};
        if (op_reg != OP_MUL) begin
            opb_next = opb_reg;
            // A zero divisor never underflows, giving all-ones quotient and remainder = dividend.
            if (!trial[XLEN]) begin
                acc_next = trial[XLEN-1:0];
                opa_next = {opa_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_next = rem_shift[XLEN-1:0];
                opa_next = {opa_reg[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_MUL;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            acc_reg   <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
        end else if (!hold) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_BUSY;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= CW'(XLEN - 1);
                        op_reg    <= op;
                        acc_reg   <= '0;
                        opa_reg   <= a;
                        opb_reg   <= b;
                    end
                end
                ST_BUSY: begin
                    acc_reg <= acc_next;
                    opa_reg <= opa_next;
                    opb_reg <= opb_next;
                    if (cnt_reg == '0) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = (op_reg == OP_DIV) ? opa_reg : acc_reg;

endmodule

// File: rtl/tl45_alu_mc.sv
// tl45 execute stage: single-cycle ALU, skip/jump resolution, multi-cycle MUL
// (and DIV/REM when TL45_ALU_DIV_EN is defined), with stall/flush handling.
module tl45_alu_mc
    import tl45_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    tl45_alu_mc_if.slave   bus
);
    logic                mc_op;
    logic                wb_op;
    logic                md_start;
    logic                md_busy;
    logic                md_done;
    logic [XLEN-1:0]     md_result;
    logic [XLEN-1:0]     sc_result;
    logic                mc_pending;
    logic                res_valid;
    logic                do_jump;
    logic [REG_BITS-1:0] of_reg;
    logic [XLEN-1:0]     of_val;
    logic [REG_BITS-1:0] dr_reg;
    logic [XLEN-1:0]     value_reg;

    assign mc_op    = is_mc_op(bus.i_opcode);
    assign wb_op    = is_wb_op(bus.i_opcode);
    assign md_start = mc_op & ~bus.i_pipe_stall & ~bus.i_pipe_flush;

    tl45_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (i_clk),
        .srst   (i_reset),
        .flush  (bus.i_pipe_flush),
        .hold   (bus.i_pipe_stall),
        .start  (md_start),
        .op     (bus.i_opcode),
        .a      (bus.i_sr1_val),
        .b      (bus.i_sr2_val),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        sc_result = '0;
        case (bus.i_opcode)
            OP_ADD, OP_ADDI: sc_result = bus.i_sr1_val + bus.i_sr2_val;
            OP_NAND:         sc_result = ~(bus.i_sr1_val & bus.i_sr2_val);
            OP_JALR:         sc_result = bus.i_pc + XLEN'(1);
            OP_LEA:          sc_result = bus.i_target_address;
            default:         sc_result = '0;
        endcase
    end

    always_comb begin
        do_jump = 1'b0;
        case (bus.i_opcode)
            OP_SKP: begin
                case (skp_mode_t'(bus.i_skp_mode))
                    SKP_EQ:  do_jump = (bus.i_sr1_val == bus.i_sr2_val);
                    SKP_LT:  do_jump = ($signed(bus.i_sr1_val) < $signed(bus.i_sr2_val));
                    SKP_NE:  do_jump = (bus.i_sr1_val != bus.i_sr2_val);
                    SKP_GE:  do_jump = ($signed(bus.i_sr1_val) >= $signed(bus.i_sr2_val));
                    default: do_jump = 1'b0;
                endcase
            end
            OP_GOTO, OP_JALR: do_jump = 1'b1;
            default:          do_jump = 1'b0;
        endcase
    end

    // The unit is only ever busy with the op still held at the input, so this is the in-flight test.
    assign mc_pending = md_busy | (mc_op & ~md_done);
    assign res_valid  = wb_op & ~mc_pending;

    always_comb begin
        of_reg = '0;
        of_val = '0;
        if (res_valid) begin
            of_reg = bus.i_dr;
            of_val = mc_op ? md_result : sc_result;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_pipe_flush) begin
            dr_reg    <= '0;
            value_reg <= '0;
        end else if (!bus.i_pipe_stall) begin
            dr_reg    <= of_reg;
            value_reg <= of_val;
        end
    end

    assign bus.o_of_reg     = of_reg;
    assign bus.o_of_val     = of_val;
    assign bus.o_dr         = dr_reg;
    assign bus.o_value      = value_reg;
    assign bus.o_ld_newpc   = do_jump & ~bus.i_pipe_stall;
    assign bus.o_pipe_flush = bus.o_ld_newpc | bus.i_pipe_flush;
    assign bus.o_pipe_stall = bus.i_pipe_stall | mc_pending;
    assign bus.o_br_pc      = (bus.i_opcode == OP_JALR) ? bus.i_sr1_val : bus.i_target_address;

endmodule

// File: tb/tb_tl45_alu_mc.sv
// Randomised self-checking bench for tl45_alu_mc against a plain-arithmetic reference model.
// Expectations for DIV/REM follow whether TL45_ALU_DIV_EN is defined.
module tb_tl45_alu_mc;
    import tl45_pkg::*;

    localparam int XLEN     = 32;
    localparam int REG_BITS = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tl45_alu_mc_if #(.XLEN(XLEN), .REG_BITS(REG_BITS)) bus ();

    tl45_alu_mc #(.XLEN(XLEN), .REG_BITS(REG_BITS)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour computed directly from the instruction semantics.
    task automatic model(input logic [3:0] op, input logic [1:0] skp,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         output bit wb, output bit mc, output logic [XLEN-1:0] val,
                         output bit jmp, output logic [XLEN-1:0] br);
        bit div_en;
        longint unsigned prod;
`ifdef TL45_ALU_DIV_EN
        div_en = 1;
`else
        div_en = 0;
`endif
        wb = 0; mc = 0; val = '0; jmp = 0; br = tgt;
        prod = 64'(a) * 64'(b);
        case (op)
            4'h0, 4'h2: begin wb = 1; val = a + b; end
            4'h1: begin wb = 1; val = ~(a & b); end
            4'h5: jmp = 1;
            4'h6: begin wb = 1; val = pc + 1; jmp = 1; br = a; end
            4'h8: begin
                case (skp)
                    2'd0: jmp = (a == b);
                    2'd1: jmp = ($signed(a) < $signed(b));
                    2'd2: jmp = (a != b);
                    default: jmp = ($signed(a) >= $signed(b));
                endcase
            end
            4'h9: begin wb = 1; val = tgt; end
            4'hA: begin wb = 1; mc = 1; val = prod[XLEN-1:0]; end
            4'hB: if (div_en) begin wb = 1; mc = 1; val = (b == 0) ? '1 : a / b; end
            4'hC: if (div_en) begin wb = 1; mc = 1; val = (b == 0) ? a : a % b; end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [1:0] skp, input logic [3:0] dr,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                          input int stall_at);
        bit wb, mc, jmp;
        logic [XLEN-1:0] val, br;
        int n;
        model(op, skp, a, b, pc, tgt, wb, mc, val, jmp, br);
        @(negedge clk);
        bus.i_opcode = op; bus.i_skp_mode = skp; bus.i_dr = dr;
        bus.i_sr1_val = a; bus.i_sr2_val = b; bus.i_pc = pc; bus.i_target_address = tgt;
        bus.i_pipe_stall = 1'b0; bus.i_pipe_flush = 1'b0;
        #1;
        chk("ld_newpc", 64'(bus.o_ld_newpc), 64'(jmp));
        chk("pipe_flush", 64'(bus.o_pipe_flush), 64'(jmp));
        if (jmp) chk("br_pc", 64'(bus.o_br_pc), 64'(br));
        if (mc) begin
            n = 0;
            while (bus.o_pipe_stall && n < 200) begin
                n++;
                chk("bubble_of", 64'(bus.o_of_reg), 64'd0);
                @(posedge clk); #1;
                chk("bubble_dr", 64'(bus.o_dr), 64'd0);
                @(negedge clk);
                bus.i_pipe_stall = (stall_at >= 0) && (n >= stall_at) && (n < stall_at + 2);
                #1;
            end
            chk("stall_cycles", 64'(n), 64'(XLEN + 1 + ((stall_at >= 0) ? 2 : 0)));
        end else begin
            chk("no_stall", 64'(bus.o_pipe_stall), 64'd0);
        end
        chk("of_reg", 64'(bus.o_of_reg), wb ? 64'(dr) : 64'd0);
        chk("of_val", 64'(bus.o_of_val), wb ? 64'(val) : 64'd0);
        @(posedge clk); #1;
        chk("o_dr", 64'(bus.o_dr), wb ? 64'(dr) : 64'd0);
        chk("o_value", 64'(bus.o_value), wb ? 64'(val) : 64'd0);
        $display("op=%0h skp=%0d dr=%0d a=%0h b=%0h -> dr=%0d value=%0h jump=%0d",
                 op, skp, dr, a, b, bus.o_dr, bus.o_value, jmp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]      op;
        logic [XLEN-1:0] a, b;
        total = 0; bad = 0;
        rst = 1'b1;
        bus.i_pipe_stall = 0; bus.i_pipe_flush = 0; bus.i_pc = '0; bus.i_target_address = '0;
        bus.i_opcode = OP_LW; bus.i_skp_mode = 0; bus.i_dr = 0; bus.i_sr1_val = 0; bus.i_sr2_val = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dr", 64'(bus.o_dr), 64'd0);
        chk("rst_value", 64'(bus.o_value), 64'd0);
        chk("rst_stall", 64'(bus.o_pipe_stall), 64'd0);
        rst = 1'b0;

        run_op(OP_ADD, 0, 3, 5, 7, 32'h10, 32'h20, -1);
        run_op(OP_MUL, 0, 2, 6, 7, 0, 0, -1);
        run_op(OP_MUL, 0, 4, 32'hFFFF_FFFF, 2, 0, 0, -1);
        run_op(OP_DIV, 0, 5, 100, 7, 0, 0, -1);
        run_op(OP_REM, 0, 6, 100, 7, 0, 0, -1);
        run_op(OP_DIV, 0, 7, 9, 0, 0, 0, -1);
        run_op(OP_REM, 0, 8, 9, 0, 0, 0, -1);
        run_op(OP_SKP, SKP_NE, 0, 3, 3, 0, 32'h40, -1);
        run_op(OP_SKP, SKP_GE, 0, 32'hFFFF_FFFF, 3, 0, 32'h40, -1);
        run_op(OP_SKP, SKP_GE, 0, 5, 3, 0, 32'h40, -1);
        run_op(OP_JALR, 0, 9, 32'h1234, 0, 32'h100, 32'h40, -1);
        run_op(OP_MUL, 0, 1, 32'h0001_0003, 32'h0000_0105, 0, 0, 5);

        // Flush ten cycles into a MUL: no result may appear afterwards.
        run_op(OP_ADD, 0, 3, 5, 7, 0, 0, -1);
        @(negedge clk);
        bus.i_opcode = OP_MUL; bus.i_dr = 2; bus.i_sr1_val = 6; bus.i_sr2_val = 7;
        repeat (10) @(negedge clk);
        bus.i_pipe_flush = 1'b1;
        #1;
        chk("flush_out", 64'(bus.o_pipe_flush), 64'd1);
        @(negedge clk);
        bus.i_pipe_flush = 1'b0; bus.i_opcode = OP_LW;
        #1;
        chk("flush_dr", 64'(bus.o_dr), 64'd0);
        chk("flush_stall", 64'(bus.o_pipe_stall), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_late_dr", 64'(bus.o_dr), 64'd0);
        chk("flush_late_val", 64'(bus.o_value), 64'd0);
        $display("flush mid-MUL -> dr=%0d value=%0h", bus.o_dr, bus.o_value);
        run_op(OP_MUL, 0, 2, 6, 7, 0, 0, -1);

        // Downstream stall holds the registered output and suppresses redirects.
        run_op(OP_ADD, 0, 3, 5, 7, 0, 0, -1);
        @(negedge clk);
        bus.i_opcode = OP_ADD; bus.i_dr = 5; bus.i_sr1_val = 1; bus.i_sr2_val = 1;
        bus.i_pipe_stall = 1'b1;
        #1;
        chk("stall_out", 64'(bus.o_pipe_stall), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_hold_dr", 64'(bus.o_dr), 64'd3);
            chk("stall_hold_val", 64'(bus.o_value), 64'd12);
        end
        @(negedge clk);
        bus.i_pipe_stall = 1'b0;
        @(posedge clk); #1;
        chk("stall_rel_dr", 64'(bus.o_dr), 64'd5);
        chk("stall_rel_val", 64'(bus.o_value), 64'd2);
        @(negedge clk);
        bus.i_opcode = OP_GOTO; bus.i_pipe_stall = 1'b1;
        #1;
        chk("stall_no_jump", 64'(bus.o_ld_newpc), 64'd0);
        bus.i_pipe_stall = 1'b0;
        #1;
        chk("jump_release", 64'(bus.o_ld_newpc), 64'd1);
        $display("stall test -> dr=%0d value=%0h", bus.o_dr, bus.o_value);

        for (int i = 0; i < 50; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 20)) : XLEN'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3))  : XLEN'($urandom);
            if ($urandom_range(0, 5) == 0) b = a;
            run_op(op, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), a, b,
                   XLEN'($urandom), XLEN'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
